// File: rtl/pipeline_cpu.sv
// Five-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with full forwarding,
// a one-bubble load-use interlock and branch/jump resolution in EX.
module pipeline_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] PC_out,
  output logic [31:0] Addr_out,
  output logic [31:0] Data_out,
  output logic        mem_w,
  output logic [2:0]  DMType_out,
  output logic [31:0] debug_data,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  logic [31:0] regs [32];
  logic [31:0] pc, ifid_pc, ifid_instr;

  logic [31:0] idex_pc, idex_rv1, idex_rv2, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [2:0]  idex_f3, idex_dmtype;
  alu_op_t     idex_alu;
  logic        idex_we, idex_mem_read, idex_mem_write, idex_branch, idex_jal, idex_jalr;
  logic        idex_a_pc, idex_a_zero, idex_b_imm;

  logic [31:0] exmem_result, exmem_store;
  logic [4:0]  exmem_rd;
  logic [2:0]  exmem_dmtype;
  logic        exmem_we, exmem_mem_read, exmem_mem_write;

  logic [31:0] memwb_value;
  logic [4:0]  memwb_rd;
  logic        memwb_we;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ifid_instr[6:0];
  assign rd     = ifid_instr[11:7];
  assign funct3 = ifid_instr[14:12];
  assign rs1    = ifid_instr[19:15];
  assign rs2    = ifid_instr[24:20];
  assign funct7 = ifid_instr[31:25];

  assign imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
  assign imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
  assign imm_b = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                  ifid_instr[30:25], ifid_instr[11:8], 1'b0};
  assign imm_u = {ifid_instr[31:12], 12'd0};
  assign imm_j = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                  ifid_instr[20], ifid_instr[30:21], 1'b0};

  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // funct3 size field -> external access type (0 W, 1 H, 2 HU, 3 B, 4 BU)
  function automatic logic [2:0] dm_decode(input logic [2:0] f3);
    case (f3)
      3'd0:    return 3'd3;
      3'd1:    return 3'd1;
      3'd4:    return 3'd4;
      3'd5:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  logic        d_we, d_mem_read, d_mem_write, d_branch, d_jal, d_jalr;
  logic        d_a_pc, d_a_zero, d_b_imm, d_use_rs1, d_use_rs2;
  alu_op_t     d_alu;
  logic [31:0] d_imm;
  logic [2:0]  d_dmtype;

  always_comb begin
    d_we = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0;
    d_branch = 1'b0; d_jal = 1'b0; d_jalr = 1'b0;
    d_a_pc = 1'b0; d_a_zero = 1'b0; d_b_imm = 1'b0;
    d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
    d_alu = ALU_ADD; d_imm = '0; d_dmtype = 3'd0;
    case (opcode)
      OP_LUI:   begin d_we = 1'b1; d_a_zero = 1'b1; d_b_imm = 1'b1; d_imm = imm_u; end
      OP_AUIPC: begin d_we = 1'b1; d_a_pc = 1'b1; d_b_imm = 1'b1; d_imm = imm_u; end
      OP_JAL:   begin d_we = 1'b1; d_jal = 1'b1; d_imm = imm_j; end
      OP_JALR:
        if (funct3 == 3'd0) begin
          d_we = 1'b1; d_jalr = 1'b1; d_use_rs1 = 1'b1; d_imm = imm_i;
        end
      OP_BRANCH:
        if (funct3 inside {3'd0, 3'd1, 3'd4, 3'd5}) begin
          d_branch = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; d_imm = imm_b;
        end
      OP_LOAD:
        if (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
          d_we = 1'b1; d_mem_read = 1'b1; d_use_rs1 = 1'b1; d_b_imm = 1'b1;
          d_imm = imm_i; d_dmtype = dm_decode(funct3);
        end
      OP_STORE:
        if (funct3 inside {3'd0, 3'd1, 3'd2}) begin
          d_mem_write = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; d_b_imm = 1'b1;
          d_imm = imm_s; d_dmtype = dm_decode(funct3);
        end
      OP_IMM:
        if ((funct3 == 3'd1 && funct7 == 7'h00) ||
            (funct3 == 3'd5 && (funct7 == 7'h00 || funct7 == 7'h20)) ||
            !(funct3 inside {3'd1, 3'd5})) begin
          d_we = 1'b1; d_use_rs1 = 1'b1; d_b_imm = 1'b1; d_imm = imm_i;
          d_alu = alu_decode(funct3, funct3 == 3'd5 && funct7[5]);
        end
      OP_REG:
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
          d_we = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1;
          d_alu = alu_decode(funct3, funct7[5]);
        end
      default: ;
    endcase
  end

  // Register read with write-back bypass; memwb_we already excludes x0.
  logic [31:0] id_rv1, id_rv2;
  assign id_rv1 = (memwb_we && memwb_rd == rs1) ? memwb_value : regs[rs1];
  assign id_rv2 = (memwb_we && memwb_rd == rs2) ? memwb_value : regs[rs2];

  logic load_use;
  assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                    ((d_use_rs1 && rs1 == idex_rd) || (d_use_rs2 && rs2 == idex_rd));

  logic [31:0] fwd_a, fwd_b, op_a, op_b, alu_y, target, ex_result;
  logic        br_cond, taken;

  // Loads in EX/MEM are never forwarded; the interlock guarantees they are not needed.
  always_comb begin
    fwd_a = idex_rv1;
    if (exmem_we && !exmem_mem_read && exmem_rd == idex_rs1) fwd_a = exmem_result;
    else if (memwb_we && memwb_rd == idex_rs1)               fwd_a = memwb_value;
    fwd_b = idex_rv2;
    if (exmem_we && !exmem_mem_read && exmem_rd == idex_rs2) fwd_b = exmem_result;
    else if (memwb_we && memwb_rd == idex_rs2)               fwd_b = memwb_value;
  end

  assign op_a = idex_a_zero ? 32'd0 : (idex_a_pc ? idex_pc : fwd_a);
  assign op_b = idex_b_imm ? idex_imm : fwd_b;

  always_comb begin
    case (idex_alu)
      ALU_ADD:  alu_y = op_a + op_b;
      ALU_SUB:  alu_y = op_a - op_b;
      ALU_SLL:  alu_y = op_a << op_b[4:0];
      ALU_SLT:  alu_y = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_y = {31'd0, op_a < op_b};
      ALU_XOR:  alu_y = op_a ^ op_b;
      ALU_SRL:  alu_y = op_a >> op_b[4:0];
      ALU_SRA:  alu_y = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:   alu_y = op_a | op_b;
      ALU_AND:  alu_y = op_a & op_b;
      default:  alu_y = op_a + op_b;
    endcase
  end

  always_comb begin
    case (idex_f3)
      3'd0:    br_cond = (fwd_a == fwd_b);
      3'd1:    br_cond = (fwd_a != fwd_b);
      3'd4:    br_cond = ($signed(fwd_a) < $signed(fwd_b));
      3'd5:    br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      default: br_cond = 1'b0;
    endcase
  end

  assign taken     = idex_jal || idex_jalr || (idex_branch && br_cond);
  assign target    = idex_jalr ? ((fwd_a + idex_imm) & 32'hFFFF_FFFE) : (idex_pc + idex_imm);
  assign ex_result = (idex_jal || idex_jalr) ? (idex_pc + 32'd4) : alu_y;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      ifid_pc <= '0; ifid_instr <= '0;
      idex_pc <= '0; idex_rv1 <= '0; idex_rv2 <= '0; idex_imm <= '0;
      idex_rs1 <= '0; idex_rs2 <= '0; idex_rd <= '0; idex_f3 <= '0; idex_dmtype <= '0;
      idex_alu <= ALU_ADD;
      idex_we <= 1'b0; idex_mem_read <= 1'b0; idex_mem_write <= 1'b0;
      idex_branch <= 1'b0; idex_jal <= 1'b0; idex_jalr <= 1'b0;
      idex_a_pc <= 1'b0; idex_a_zero <= 1'b0; idex_b_imm <= 1'b0;
      exmem_result <= '0; exmem_store <= '0; exmem_rd <= '0; exmem_dmtype <= '0;
      exmem_we <= 1'b0; exmem_mem_read <= 1'b0; exmem_mem_write <= 1'b0;
      memwb_value <= '0; memwb_rd <= '0; memwb_we <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      // Flush has priority over the load-use hold.
      if (taken) begin
        pc <= target;
        ifid_pc <= '0;
        ifid_instr <= '0;
      end else if (!load_use) begin
        pc <= pc + 32'd4;
        ifid_pc <= pc;
        ifid_instr <= instr_in;
      end

      if (taken || load_use) begin
        idex_rs1 <= '0; idex_rs2 <= '0; idex_rd <= '0;
        idex_we <= 1'b0; idex_mem_read <= 1'b0; idex_mem_write <= 1'b0;
        idex_branch <= 1'b0; idex_jal <= 1'b0; idex_jalr <= 1'b0;
        idex_a_pc <= 1'b0; idex_a_zero <= 1'b0; idex_b_imm <= 1'b0;
        idex_alu <= ALU_ADD; idex_imm <= '0; idex_pc <= '0;
        idex_rv1 <= '0; idex_rv2 <= '0; idex_f3 <= '0; idex_dmtype <= '0;
      end else begin
        idex_rs1 <= rs1; idex_rs2 <= rs2; idex_rd <= rd;
        idex_we <= d_we && (rd != 5'd0);
        idex_mem_read <= d_mem_read; idex_mem_write <= d_mem_write;
        idex_branch <= d_branch; idex_jal <= d_jal; idex_jalr <= d_jalr;
        idex_a_pc <= d_a_pc; idex_a_zero <= d_a_zero; idex_b_imm <= d_b_imm;
        idex_alu <= d_alu; idex_imm <= d_imm; idex_pc <= ifid_pc;
        idex_rv1 <= id_rv1; idex_rv2 <= id_rv2; idex_f3 <= funct3; idex_dmtype <= d_dmtype;
      end

      exmem_result <= ex_result;
      exmem_store <= fwd_b;
      exmem_rd <= idex_rd;
      exmem_dmtype <= idex_dmtype;
      exmem_we <= idex_we;
      exmem_mem_read <= idex_mem_read;
      exmem_mem_write <= idex_mem_write;

      memwb_value <= exmem_mem_read ? Data_in : exmem_result;
      memwb_rd <= exmem_rd;
      memwb_we <= exmem_we;

      if (memwb_we) regs[memwb_rd] <= memwb_value;
    end
  end

  assign PC_out     = pc;
  assign Addr_out   = exmem_result;
  assign Data_out   = exmem_store;
  assign mem_w      = exmem_mem_write;
  assign DMType_out = exmem_dmtype;
  assign debug_data = memwb_value;
  assign reg_data   = regs[reg_sel];

endmodule

// File: tb/tb_pipeline_cpu.sv
// Bench for pipeline_cpu: small programs in a bench-side ROM, register and store
// expectations queued when each program is loaded and checked as the core produces them.
module tb_pipeline_cpu;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, Data_in, PC_out, Addr_out, Data_out, debug_data, reg_data;
  logic        mem_w;
  logic [2:0]  DMType_out;
  logic [4:0]  reg_sel;

  logic [31:0] rom  [64];
  logic [31:0] dmem [16];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic [4:0] r; logic [31:0] v; } reg_exp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; logic [2:0] t; } st_exp_t;
  reg_exp_t reg_q[$];
  st_exp_t  st_q[$];

  localparam logic [6:0]  OPI  = 7'b0010011;
  localparam logic [6:0]  LDO  = 7'b0000011;
  localparam logic [6:0]  JLRO = 7'b1100111;
  localparam logic [31:0] LOOP = 32'h0000_006F;

  pipeline_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .Data_in(Data_in),
    .PC_out(PC_out), .Addr_out(Addr_out), .Data_out(Data_out), .mem_w(mem_w),
    .DMType_out(DMType_out), .debug_data(debug_data), .reg_sel(reg_sel), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  assign instr_in = rom[PC_out[7:2]];
  assign Data_in  = dmem[Addr_out[5:2]];

  function automatic logic [31:0] itype(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] rtype(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] stype(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] btype(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] jtype(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One clock; the store monitor sees mem_w for the edge that follows.
  task automatic cycle();
    st_exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (mem_w) begin
      dmem[Addr_out[5:2]] = Data_out;
      if (st_q.size() == 0) check("spurious_store", {31'd0, mem_w}, 32'd0);
      else begin
        e = st_q.pop_front();
        check("store_addr", Addr_out, e.a);
        check("store_data", Data_out, e.d);
        check("store_type", {29'd0, DMType_out}, {29'd0, e.t});
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic expect_reg(logic [4:0] r, logic [31:0] v);
    reg_q.push_back('{r, v});
  endtask

  task automatic check_regs();
    reg_exp_t e;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      reg_sel = e.r;
      #1;
      check($sformatf("x%0d", e.r), reg_data, e.v);
    end
  endtask

  task automatic begin_prog();
    rst = 1'b0;
    cycle();
    for (int i = 0; i < 64; i++) rom[i] = LOOP;
  endtask

  task automatic go();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    reg_sel = 5'd0;
    for (int i = 0; i < 16; i++) dmem[i] = 32'd0;
    for (int i = 0; i < 64; i++) rom[i] = LOOP;
    cycle(); cycle();
    check("rst_pc", PC_out, 32'd0);
    check("rst_mem_w", {31'd0, mem_w}, 32'd0);
    check("rst_addr", Addr_out, 32'd0);
    check("rst_wdata", Data_out, 32'd0);
    check("rst_dmtype", {29'd0, DMType_out}, 32'd0);
    check("rst_debug", debug_data, 32'd0);

    // load, immediate, AND with mixed forwarding
    begin_prog();
    dmem[0] = 32'h8765_4321;
    rom[0] = itype(12'd0, 5'd0, 3'd2, 5'd15, LDO);
    rom[1] = itype(12'd15, 5'd0, 3'd0, 5'd4, OPI);
    rom[2] = rtype(7'h00, 5'd4, 5'd15, 3'd7, 5'd7);
    expect_reg(5'd15, 32'h8765_4321);
    expect_reg(5'd4, 32'h0000_000F);
    expect_reg(5'd7, 32'h0000_0001);
    go(); run(20); check_regs();

    // load-use interlock
    begin_prog();
    dmem[0] = 32'h0000_0011;
    rom[0] = itype(12'd0, 5'd0, 3'd2, 5'd1, LDO);
    rom[1] = rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    expect_reg(5'd1, 32'h0000_0011);
    expect_reg(5'd2, 32'h0000_0022);
    go();
    cycle(); check("lu_pc1", PC_out, 32'd4);
    cycle(); check("lu_pc2", PC_out, 32'd8);
    cycle(); check("lu_pc_hold", PC_out, 32'd8);
    cycle(); check("lu_pc_resume", PC_out, 32'd12);
    run(15); check_regs();

    // EX/MEM and MEM/WB forwarding
    begin_prog();
    rom[0] = itype(12'd5, 5'd0, 3'd0, 5'd1, OPI);
    rom[1] = rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    rom[2] = rtype(7'h20, 5'd1, 5'd2, 3'd0, 5'd3);
    expect_reg(5'd1, 32'd5);
    expect_reg(5'd2, 32'd10);
    expect_reg(5'd3, 32'd5);
    go(); run(20); check_regs();

    // stores: forwarded data, misaligned halfword passed through
    begin_prog();
    rom[0] = itype(12'd15, 5'd0, 3'd0, 5'd4, OPI);
    rom[1] = stype(12'd8, 5'd4, 5'd0, 3'd2);
    rom[2] = itype(12'hFFE, 5'd0, 3'd0, 5'd5, OPI);
    rom[3] = stype(12'd2, 5'd5, 5'd4, 3'd1);
    st_q.push_back('{32'd8, 32'h0000_000F, 3'd0});
    st_q.push_back('{32'd17, 32'hFFFF_FFFE, 3'd1});
    go(); run(20);
    check("stores_pending", st_q.size(), 32'd0);

    // taken branches flush the two younger instructions
    begin_prog();
    rom[0] = btype(13'd12, 5'd0, 5'd0, 3'd0);
    rom[1] = itype(12'd1, 5'd0, 3'd0, 5'd5, OPI);
    rom[2] = itype(12'd2, 5'd0, 3'd0, 5'd5, OPI);
    rom[3] = itype(12'd1, 5'd0, 3'd0, 5'd1, OPI);
    rom[4] = btype(13'd8, 5'd0, 5'd1, 3'd1);
    rom[5] = itype(12'd9, 5'd0, 3'd0, 5'd5, OPI);
    rom[6] = itype(12'd4, 5'd1, 3'd0, 5'd6, OPI);
    expect_reg(5'd5, 32'd0);
    expect_reg(5'd1, 32'd1);
    expect_reg(5'd6, 32'd5);
    go();
    cycle(); cycle(); cycle();
    check("beq_target_pc", PC_out, 32'd12);
    cycle(); cycle(); cycle(); cycle();
    check("bne_target_pc", PC_out, 32'd24);
    run(15); check_regs();

    // ALU mix, JAL/JALR link and flush, x0 never forwarded
    begin_prog();
    rom[0]  = {20'h12345, 5'd8, 7'b0110111};
    rom[1]  = itype(12'h678, 5'd8, 3'd0, 5'd8, OPI);
    rom[2]  = itype(12'h004, 5'd8, 3'd1, 5'd9, OPI);
    rom[3]  = itype(12'hFFF, 5'd0, 3'd0, 5'd11, OPI);
    rom[4]  = itype(12'h01C, 5'd11, 3'd5, 5'd12, OPI);
    rom[5]  = itype(12'h404, 5'd11, 3'd5, 5'd13, OPI);
    rom[6]  = rtype(7'h00, 5'd0, 5'd11, 3'd2, 5'd14);
    rom[7]  = rtype(7'h00, 5'd11, 5'd0, 3'd3, 5'd16);
    rom[8]  = jtype(21'd8, 5'd17);
    rom[9]  = itype(12'd9, 5'd0, 3'd0, 5'd18, OPI);
    rom[10] = itype(12'd5, 5'd0, 3'd0, 5'd0, OPI);
    rom[11] = rtype(7'h00, 5'd0, 5'd0, 3'd0, 5'd20);
    rom[12] = itype(12'h0FF, 5'd8, 3'd4, 5'd21, OPI);
    rom[13] = {20'h00000, 5'd22, 7'b0010111};
    rom[14] = itype(12'd12, 5'd22, 3'd0, 5'd23, JLRO);
    rom[15] = itype(12'd1, 5'd0, 3'd0, 5'd24, OPI);
    expect_reg(5'd8, 32'h1234_5678);
    expect_reg(5'd9, 32'h2345_6780);
    expect_reg(5'd11, 32'hFFFF_FFFF);
    expect_reg(5'd12, 32'h0000_000F);
    expect_reg(5'd13, 32'hFFFF_FFFF);
    expect_reg(5'd14, 32'd1);
    expect_reg(5'd16, 32'd1);
    expect_reg(5'd17, 32'd36);
    expect_reg(5'd18, 32'd0);
    expect_reg(5'd20, 32'd0);
    expect_reg(5'd21, 32'h1234_5687);
    expect_reg(5'd22, 32'd52);
    expect_reg(5'd23, 32'd60);
    expect_reg(5'd24, 32'd0);
    expect_reg(5'd0, 32'd0);
    go(); run(40); check_regs();

    // reset asserted mid-program
    begin_prog();
    rom[0] = itype(12'd5, 5'd0, 3'd0, 5'd1, OPI);
    rom[1] = rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    rom[2] = rtype(7'h20, 5'd1, 5'd2, 3'd0, 5'd3);
    go(); run(6);
    rst = 1'b0;
    cycle();
    check("midrst_pc", PC_out, 32'd0);
    check("midrst_mem_w", {31'd0, mem_w}, 32'd0);
    for (int r = 0; r < 32; r++) expect_reg(5'(r), 32'd0);
    check_regs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
